// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel-rate divider, X/Y position counters and
// registered sync / display-enable / strobe outputs.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   en            run enable; all state holds while low
//   CounterX      current pixel column, 0..H_TOTAL-1
//   CounterY      current line, 0..V_TOTAL-1
//   inDisplayArea high inside the visible region
//   vga_hs/vga_vs sync pins, polarity set by SYNC_ACTIVE_LOW
//   pix_tick      one-clk strobe after each counter advance
//   frame_start   pix_tick that lands on (0,0)
module vga_sync_gen #(
  parameter int CLK_DIV         = 4,
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] CounterX,
  output logic [9:0] CounterY,
  output logic       inDisplayArea,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SAL     = (SYNC_ACTIVE_LOW != 0);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          tick_q, tick_d;
  logic          fs_q, fs_d;
  logic          adv;

  always_comb begin
    adv    = en && (div_q == DIV_LAST);
    div_d  = div_q;
    x_d    = x_q;
    y_d    = y_q;
    if (en) begin
      div_d = adv ? '0 : div_q + DW'(1);
    end
    if (adv) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Derived outputs use the next counter pair so they register
    // on the same edge as the counters and never lag by a pixel.
    de_d   = (x_d < H_ACT) && (y_d < V_ACT);
    hs_d   = ((x_d >= HS_BEG) && (x_d < HS_END)) ^ SAL;
    vs_d   = ((y_d >= VS_BEG) && (y_d < VS_END)) ^ SAL;
    tick_d = adv;
    fs_d   = adv && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      de_q   <= 1'b1;
      hs_q   <= SAL;
      vs_q   <= SAL;
      tick_q <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      tick_q <= tick_d;
      fs_q   <= fs_d;
    end
  end

  assign CounterX      = x_q;
  assign CounterY      = y_q;
  assign inDisplayArea = de_q;
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign pix_tick      = tick_q;
  assign frame_start   = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three builds (default, small geometry,
// CLK_DIV=1 with active-high sync) checked against an arithmetic model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       pt;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_de, a_hs, a_vs, a_pt, a_fs;
  logic b_de, b_hs, b_vs, b_pt, b_fs;
  logic c_de, c_hs, c_vs, c_pt, c_fs;

  vga_sync_gen u_a (
    .clk(clk), .rst(rst), .en(en),
    .CounterX(a_x), .CounterY(a_y), .inDisplayArea(a_de),
    .vga_hs(a_hs), .vga_vs(a_vs),
    .pix_tick(a_pt), .frame_start(a_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(4),
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_ACTIVE_LOW(1)
  ) u_b (
    .clk(clk), .rst(rst), .en(en),
    .CounterX(b_x), .CounterY(b_y), .inDisplayArea(b_de),
    .vga_hs(b_hs), .vga_vs(b_vs),
    .pix_tick(b_pt), .frame_start(b_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .SYNC_ACTIVE_LOW(0)
  ) u_c (
    .clk(clk), .rst(rst), .en(en),
    .CounterX(c_x), .CounterY(c_y), .inDisplayArea(c_de),
    .vga_hs(c_hs), .vga_vs(c_vs),
    .pix_tick(c_pt), .frame_start(c_fs)
  );

  obs_t a_obs, b_obs, c_obs;
  assign a_obs = {a_x, a_y, a_de, a_hs, a_vs, a_pt, a_fs};
  assign b_obs = {b_x, b_y, b_de, b_hs, b_vs, b_pt, b_fs};
  assign c_obs = {c_x, c_y, c_de, c_hs, c_vs, c_pt, c_fs};

  // Model state: number of enabled edges since reset, and whether
  // the most recent edge was enabled.
  longint e_cnt;
  bit     e_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_cnt  <= 0;
      e_last <= 1'b0;
    end else begin
      e_last <= en;
      if (en) e_cnt <= e_cnt + 1;
    end
  end

  function automatic obs_t model(
    input int div, input int ha, input int hfp, input int hsy,
    input int hbp, input int va, input int vfp, input int vsy,
    input int vbp, input bit sal, input longint e, input bit el
  );
    obs_t   o;
    longint ht, vt, p, x, y;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    p  = e / div;
    x  = p % ht;
    y  = (p / ht) % vt;
    o.x  = 10'(x);
    o.y  = 10'(y);
    o.de = (x < ha) && (y < va);
    o.hs = ((x >= ha + hfp) && (x < ha + hfp + hsy)) ^ sal;
    o.vs = ((y >= va + vfp) && (y < va + vfp + vsy)) ^ sal;
    o.pt = el && (e % div == 0);
    o.fs = o.pt && (p % (ht * vt) == 0);
    return o;
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  task automatic chk_obs(input string n, input obs_t g, input obs_t e);
    chk({n, ".X"},  int'(g.x),  int'(e.x));
    chk({n, ".Y"},  int'(g.y),  int'(e.y));
    chk({n, ".de"}, int'(g.de), int'(e.de));
    chk({n, ".hs"}, int'(g.hs), int'(e.hs));
    chk({n, ".vs"}, int'(g.vs), int'(e.vs));
    chk({n, ".pt"}, int'(g.pt), int'(e.pt));
    chk({n, ".fs"}, int'(g.fs), int'(e.fs));
  endtask

  task automatic check_all();
    chk_obs("A", a_obs,
      model(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, e_cnt, e_last));
    chk_obs("B", b_obs,
      model(4, 20, 3, 5, 4, 10, 2, 2, 3, 1'b1, e_cnt, e_last));
    chk_obs("C", c_obs,
      model(1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, e_cnt, e_last));
  endtask

  // Frame-period tracking on build B (32 x 17 pixels x 4 clk).
  longint cyc     = 0;
  longint last_fs = -1;
  int     n_per   = 0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      check_all();
      if (!e_last) last_fs = -1;
      if (b_fs) begin
        if (last_fs >= 0) begin
          chk("B.frame_period", int'(cyc - last_fs), 2176);
          n_per++;
        end
        last_fs = cyc;
      end
    end
  endtask

  initial begin
    en  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_obs("A.rst", a_obs, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    chk("C.rst.hs", int'(c_hs), 0);

    rst = 1'b0;
    en  = 1'b1;
    step(3);
    chk("A.lat3.X", int'(a_x), 0);
    chk("A.lat3.pt", int'(a_pt), 0);
    step(1);
    chk("A.lat4.X", int'(a_x), 1);
    chk("A.lat4.pt", int'(a_pt), 1);
    chk("C.lat4.X", int'(c_x), 4);

    step(396);
    chk("A.X100", int'(a_x), 100);
    en = 1'b0;
    step(10);
    chk("A.hold.X", int'(a_x), 100);
    chk("A.hold.pt", int'(a_pt), 0);
    en = 1'b1;
    step(3300);

    for (int i = 0; i < 2000; i++) begin
      en = ($urandom % 4) != 0;
      step(1);
    end

    en = 1'b1;
    step(5000);
    chk("B.period_seen", int'(n_per > 0), 1);

    #2 rst = 1'b1;
    #1;
    check_all();
    chk_obs("A.arst", a_obs, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    chk("B.arst.X", int'(b_x), 0);
    chk("C.arst.hs", int'(c_hs), 0);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    chk("A.relat3.X", int'(a_x), 0);
    step(1);
    chk("A.relat4.X", int'(a_x), 1);
    chk("A.relat4.fs", int'(a_fs), 0);
    step(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing master for the VGA output path. It divides the system clock down to a pixel-rate strobe and runs the horizontal and vertical position counters. It drives the `CounterX`/`CounterY`/`inDisplayArea` bus consumed by the pixel/pattern generators and drives the `vga_hs`/`vga_vs` sync pins. All outputs are registered and mutually consistent with the current counter pair. Default parameters give 640x480 @ 60 Hz from a 100 MHz clock.

## Interface

**Parameters**

- `CLK_DIV`, 4: system clocks per pixel; must be ≥1.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BP`, 48: horizontal back porch. H_TOTAL = 800, and must be ≤1024.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch. V_TOTAL = 525, and must be ≤1024.
- `SYNC_ACTIVE_LOW`, 1: when 1, sync pins are low during the sync pulse; when 0, high.

**Ports**

- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `en`, in, 1: run enable. When low, all state holds.
- `CounterX`, out, 10: current pixel column, 0..H_TOTAL-1.
- `CounterY`, out, 10: current line, 0..V_TOTAL-1.
- `inDisplayArea`, out, 1: high when `CounterX` < H_ACTIVE and `CounterY` < V_ACTIVE.
- `vga_hs`, out, 1: horizontal sync pin.
- `vga_vs`, out, 1: vertical sync pin.
- `pix_tick`, out, 1: one-clk strobe, high in the cycle immediately after the counters advance.
- `frame_start`, out, 1: one-clk strobe, high together with `pix_tick` when the counters have just wrapped to (0,0).

## Operation

- **Divider `div_cnt`:**
  - Range 0..CLK_DIV-1, reset value 0.
  - Increments on each clk edge while `en`=1.
  - On the edge where `div_cnt`=CLK_DIV-1: wraps to 0 and performs one pixel advance.
  - CLK_DIV=1: every enabled edge is an advance, so `pix_tick` stays high continuously while `en`=1.
- **Pixel advance:**
  - `CounterX` increments.
  - At H_TOTAL-1: `CounterX` goes to 0 and `CounterY` increments.
  - At (H_TOTAL-1, V_TOTAL-1): both go to 0.
  - No other counter values are reachable.
- **Derived outputs:** registered, and computed from the next counter values, so they always match the current `CounterX`/`CounterY` (no one-pixel skew).
  - hsync is asserted when H_ACTIVE+H_FP ≤ `CounterX` < H_ACTIVE+H_FP+H_SYNC; with defaults, X = 656..751.
  - vsync is asserted when V_ACTIVE+V_FP ≤ `CounterY` < V_ACTIVE+V_FP+V_SYNC; with defaults, Y = 490..491.
  - vsync depends only on `CounterY`.
  - Pin level = asserted XOR `SYNC_ACTIVE_LOW`.
- **`en`=0:**
  - `div_cnt`, the counters and all derived outputs hold.
  - `pix_tick` and `frame_start` are 0.
  - On resume, the divider continues from its held value.
- **Reset values:**
  - `div_cnt`=0, `CounterX`=0, `CounterY`=0, `inDisplayArea`=1.
  - `vga_hs` and `vga_vs` at their deasserted level (1 with defaults).
  - `pix_tick`=0, `frame_start`=0.
  - Reset release does not generate a `frame_start`.
- **Reset mid-frame:** takes effect immediately, with no clock edge needed. All outputs go to their reset values, and the next frame begins from (0,0).

## Timing

- Latency from reset release with `en`=1:
  - Edges 1..3 take `div_cnt` to 1, 2, 3.
  - Edge 4 advances to X=1, and `pix_tick` is high for the following cycle.
  - From then on, `pix_tick` repeats every CLK_DIV clocks.
- Consumers register on `clk` qualified by `pix_tick`. `CounterX`/`CounterY` are stable for CLK_DIV clocks after each advance.
- Periods with default parameters:
  - Line period: H_TOTAL·CLK_DIV = 3200 clk.
  - Frame period: 800·525·4 = 1,680,000 clk.
- `frame_start` rises on the same edge that loads (0,0), and `pix_tick` is also high in that cycle.
- Sync and `inDisplayArea` change on the same edge as the counter that governs them.

## Test plan

1. Hold `rst`=1, then release with `en`=1: outputs read (0,0,1,hs=1,vs=1,0,0). The first advance to X=1 occurs on the 4th edge, and the `pix_tick` period is 4 clk.
2. Run one line. At X=639→640, `inDisplayArea` 1→0. `vga_hs` is 0 exactly for X=656..751, i.e. 96·4 = 384 clk. X=799→0 with Y 0→1, and `inDisplayArea` returns to 1.
3. Run a full frame:
   - `vga_vs` is 0 only for Y=490..491, i.e. 2 lines (1600 pixels).
   - `inDisplayArea` stays 0 for Y≥480.
   - (799,524)→(0,0) with `frame_start`=1 for 1 clk.
   - The next `frame_start` follows 1,680,000 clk later.
4. Drop `en` for 10 clk at X=100: counters, `div_cnt` and sync hold, with no strobes. After resume, the next advance comes after the remaining divider count.
5. Assert `rst` asynchronously, between edges, at (700,300): outputs reach their reset values before the next edge. After release, behaviour matches scenario 1.
6. Build with CLK_DIV=1 and SYNC_ACTIVE_LOW=0: `pix_tick` is constantly 1, X advances every clk, and `vga_hs` is high only for X=656..751.
